// File: rtl/exc_sequencer_pkg.sv
// Shared exception-sequencer types: ExcCodes, FSM states, vectors.
// Imported by the sequencer, its redirect holder and the bench.
package exc_pkg;

  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_ADES    = 5'd5;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_RI      = 5'd10;
  localparam logic [4:0] EXC_OV      = 5'd12;

  localparam logic [31:0] DEF_HANDLER_ADDR = 32'h0000_4180;
  localparam logic [31:0] DEF_RESET_PC     = 32'h0000_3000;

  typedef enum logic [1:0] {
    S_RUN,
    S_FLUSH,
    S_ERET,
    S_REDIR
  } exc_state_e;

  function automatic logic [2:0] flush_init(input int n);
    return 3'(n - 1);
  endfunction

endpackage

// File: rtl/exc_sequencer_if.sv
// Fetch-redirect valid/ready channel.
// The sequencer is master; fetch is slave.
interface exc_redir_if;

  logic        redir_valid;
  logic [31:0] redir_addr;
  logic        redir_ready;

  modport master (
    output redir_valid,
    output redir_addr,
    input  redir_ready
  );

  modport slave (
    input  redir_valid,
    input  redir_addr,
    output redir_ready
  );

endinterface

// File: rtl/exc_sequencer_redir_hold.sv
// Holding register for the fetch redirect offer.
// Loaded by the FSM, dropped on handshake or reset.
module redir_hold (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_addr,
  input  logic        ready,
  output logic        valid,
  output logic [31:0] addr
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      addr  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      addr  <= load_addr;
    end else if (valid && ready) begin
      valid <= 1'b0;
      addr  <= '0;
    end
  end

endmodule

// File: rtl/exc_sequencer.sv
// Exception/interrupt entry and eret sequencer between M stage and CP0.
// Flushes the pipe and redirects fetch to the handler or to EPC.
module exc_sequencer
  import exc_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = DEF_HANDLER_ADDR,
  parameter logic [31:0] RESET_PC     = DEF_RESET_PC,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             m_valid,
  input  logic [31:0]      m_pc,
  input  logic [4:0]       m_exc_code,
  input  logic             m_bd,
  input  logic [31:0]      m_badvaddr,
  input  logic             m_is_eret,
  input  logic [5:0]       hw_int,

  input  logic             cp0_req,
  input  logic [31:0]      cp0_epc,
  output logic [4:0]       cp0_exc_code,
  output logic [31:0]      cp0_vpc,
  output logic             cp0_bd,
  output logic [31:0]      cp0_badvaddr,
  output logic [5:0]       cp0_hwint,
  output logic             cp0_exlclr,

  output logic             flush,
  exc_redir_if.master      rd,
  output logic             busy,
  output logic [CNT_W-1:0] exc_count
);

  exc_state_e       state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [31:0]      target_q, target_d;
  logic [31:0]      last_pc_q;
  logic [CNT_W-1:0] exc_count_q;
  logic             inc;
  logic             load;
  logic             hold_valid;
  logic [31:0]      hold_addr;
  logic             run;

  assign run = (state_q == S_RUN);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    target_d   = target_q;
    flush      = 1'b0;
    cp0_exlclr = 1'b0;
    inc        = 1'b0;
    unique case (state_q)
      S_RUN: begin
        // cp0_req outranks a coincident eret: no EXL clear then
        if (cp0_req) begin
          flush    = 1'b1;
          inc      = 1'b1;
          target_d = HANDLER_ADDR;
          if (FLUSH_CYCLES == 1) begin
            state_d = S_REDIR;
          end else begin
            state_d = S_FLUSH;
            cnt_d   = flush_init(FLUSH_CYCLES);
          end
        end else if (m_valid && m_is_eret) begin
          flush      = 1'b1;
          cp0_exlclr = 1'b1;
          target_d   = cp0_epc;
          state_d    = S_ERET;
        end
      end
      S_FLUSH: begin
        flush = 1'b1;
        if (cnt_q <= 3'd1) begin
          state_d = S_REDIR;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_ERET: begin
        flush   = 1'b1;
        state_d = S_REDIR;
      end
      S_REDIR: begin
        flush = 1'b1;
        if (hold_valid && rd.redir_ready) begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  assign load = (state_d == S_REDIR) && (state_q != S_REDIR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_RUN;
      cnt_q       <= '0;
      target_q    <= '0;
      last_pc_q   <= RESET_PC;
      exc_count_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      if (m_valid) begin
        last_pc_q <= m_pc;
      end
      if (inc) begin
        exc_count_q <= exc_count_q + CNT_W'(1);
      end
    end
  end

  redir_hold u_hold (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_addr (target_d),
    .ready     (rd.redir_ready),
    .valid     (hold_valid),
    .addr      (hold_addr)
  );

  assign rd.redir_valid = hold_valid;
  assign rd.redir_addr  = hold_addr;

  // Outside RUN, CP0 sees no cause so it cannot re-enter
  assign cp0_exc_code = (run && m_valid) ? m_exc_code : EXC_INT;
  assign cp0_bd       = run && m_valid && m_bd;
  assign cp0_hwint    = run ? hw_int : 6'd0;
  assign cp0_badvaddr = m_badvaddr;
  assign cp0_vpc      = m_valid ? m_pc : last_pc_q;
  assign busy         = !run;
  assign exc_count    = exc_count_q;

endmodule
